// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor processing BITS_PER_CYCLE bits
// per clock through a chained full-adder slice with a registered inter-slice carry.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, accepted only when busy=0
//   mode                0 = a+b+cin, 1 = a-b-cin (sampled with start)
//   a, b                WIDTH-bit operands (sampled with start)
//   cin                 carry-in (add) / borrow-in (subtract)
//   busy                high while computing
//   done                one-cycle pulse, result/cout/ovf valid
//   result              sum or difference
//   cout                carry-out (add) / borrow-out (subtract)
//   ovf                 two's-complement signed overflow
module serial_addsub #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned BPC   = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
  localparam int unsigned N     = WIDTH / BPC;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - BPC);

  // Elaboration-time parameter legality
  generate
    if (WIDTH < 2 || BITS_PER_CYCLE == 0 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept_c;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             mode_q;
  logic [CNT_W-1:0] slice_q;

  logic [31:0]      lsb_c;
  logic [BPC-1:0]   a_sl_c;
  logic [BPC-1:0]   b_sl_c;
  logic [BPC-1:0]   sum_sl_c;
  logic [BPC:0]     chain_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is honoured only when not busy (IDLE or DONE)
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          accept_c = 1'b1;
        end
      end
      S_RUN: begin
        if (slice_q == LAST_SLICE) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          accept_c = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Current slice: BPC chained full adders fed by the registered carry
  always_comb begin
    lsb_c    = 32'(slice_q) * BPC;
    a_sl_c   = BPC'(a_q >> lsb_c);
    b_sl_c   = BPC'(b_q >> lsb_c);
    sum_sl_c = '0;
    chain_c  = '0;
    chain_c[0] = carry_q;
    for (int i = 0; i < int'(BPC); i++) begin
      sum_sl_c[i]   = a_sl_c[i] ^ b_sl_c[i] ^ chain_c[i];
      chain_c[i+1]  = (a_sl_c[i] & b_sl_c[i]) | (chain_c[i] & (a_sl_c[i] ^ b_sl_c[i]));
    end
  end

  // Status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == S_RUN);
      done <= (state_d == S_DONE);
    end
  end

  // Operand capture and per-slice datapath; subtract is a + ~b + ~borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      slice_q <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= mode ? ~b : b;
      carry_q <= mode ? ~cin : cin;
      mode_q  <= mode;
      slice_q <= '0;
    end else if (state_q == S_RUN) begin
      result  <= (result & ~(SLICE_MASK << lsb_c)) | (WIDTH'(sum_sl_c) << lsb_c);
      carry_q <= chain_c[BPC];
      slice_q <= slice_q + CNT_W'(1);
      // Last slice: chain_c[BPC-1] is the carry into the operand MSB
      if (slice_q == LAST_SLICE) begin
        cout <= mode_q ? ~chain_c[BPC] : chain_c[BPC];
        ovf  <= chain_c[BPC-1] ^ chain_c[BPC];
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit/1-bit-per-cycle instance checked every
// cycle against an arithmetic model, plus a 16-bit/4-bit-per-cycle instance
// checked with hand-computed vectors.
module tb_serial_addsub;

  localparam int unsigned N8  = 8;
  localparam int unsigned N16 = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic        cin   = 1'b0;
  logic [7:0]  a     = 8'h00;
  logic [7:0]  b     = 8'h00;
  logic        busy, done, cout, ovf;
  logic [7:0]  result;

  logic        start2 = 1'b0;
  logic        mode2  = 1'b0;
  logic        cin2   = 1'b0;
  logic [15:0] a2     = 16'h0000;
  logic [15:0] b2     = 16'h0000;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] result2;

  int compared   = 0;
  int mismatched = 0;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer maths on the sampled operands
  function automatic void model_op(input logic m, input logic [7:0] x, input logic [7:0] y,
                                   input logic c, output logic [7:0] r,
                                   output logic co, output logic ov);
    int ux, uy, sx, sy, sr, ci;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (!m) begin
      r  = 8'(ux + uy + ci);
      co = (ux + uy + ci) > 255;
      sr = sx + sy + ci;
    end else begin
      r  = 8'(ux - uy - ci);
      co = ux < (uy + ci);
      sr = sx - sy - ci;
    end
    ov = (sr > 127) || (sr < -128);
  endfunction

  // Model timing: age = edges since the accepting edge (-1 when none pending)
  int         age    = -1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] e_res  = 8'h00;
  logic       e_co   = 1'b0;
  logic       e_ov   = 1'b0;
  logic [7:0] h_res  = 8'h00;
  logic       h_co   = 1'b0;
  logic       h_ov   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age    = -1;
      m_busy = 1'b0;
      m_done = 1'b0;
      h_res  = 8'h00;
      h_co   = 1'b0;
      h_ov   = 1'b0;
    end else begin
      if (!m_busy && start) begin
        age = 0;
        model_op(mode, a, b, cin, e_res, e_co, e_ov);
      end else if (age >= 0 && age < int'(N8)) begin
        age = age + 1;
      end else begin
        age = -1;
      end
      m_busy = (age >= 0) && (age < int'(N8));
      m_done = (age == int'(N8));
      if (m_done) begin
        h_res = e_res;
        h_co  = e_co;
        h_ov  = e_ov;
      end
    end
  end

  // Per-cycle compare of the 8-bit instance against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (m_done) begin
      chk("result@done", 32'(result), 32'(e_res));
      chk("cout@done",   32'(cout),   32'(e_co));
      chk("ovf@done",    32'(ovf),    32'(e_ov));
    end else if (!m_busy) begin
      chk("result@hold", 32'(result), 32'(h_res));
      chk("cout@hold",   32'(cout),   32'(h_co));
      chk("ovf@hold",    32'(ovf),    32'(h_ov));
    end
  end

  // One 8-bit operation; returns at the negedge of the DONE cycle
  task automatic run8(input logic m, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic [7:0] er, input logic ec, input logic eo, input string tag);
    int k  = 0;
    int nb = 0;
    start = 1'b1; mode = m; a = ia; b = ib; cin = ic;
    do begin
      @(negedge clk);
      k++;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); cin = 1'($urandom);
      if (busy) nb++;
    end while (!done && k < 40);
    chk({tag, " latency"},  32'(k),      32'(N8 + 1));
    chk({tag, " busy_cyc"}, 32'(nb),     32'(N8));
    chk({tag, " result"},   32'(result), 32'(er));
    chk({tag, " cout"},     32'(cout),   32'(ec));
    chk({tag, " ovf"},      32'(ovf),    32'(eo));
  endtask

  task automatic run16(input logic m, input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic [15:0] er, input logic ec, input logic eo, input string tag);
    int k  = 0;
    int nb = 0;
    start2 = 1'b1; mode2 = m; a2 = ia; b2 = ib; cin2 = ic;
    do begin
      @(negedge clk);
      k++;
      start2 = 1'b0;
      a2 = 16'($urandom); b2 = 16'($urandom);
      if (busy2) nb++;
    end while (!done2 && k < 40);
    chk({tag, " latency"},  32'(k),       32'(N16 + 1));
    chk({tag, " busy_cyc"}, 32'(nb),      32'(N16));
    chk({tag, " result"},   32'(result2), 32'(er));
    chk({tag, " cout"},     32'(cout2),   32'(ec));
    chk({tag, " ovf"},      32'(ovf2),    32'(eo));
  endtask

  initial begin
    int k;
    int ndone;
    #1 rst_n = 1'b0;
    #2;
    chk("rst busy",   32'(busy),   32'd0);
    chk("rst done",   32'(done),   32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cout",   32'(cout),   32'd0);
    chk("rst ovf",    32'(ovf),    32'd0);
    chk("rst result16", 32'(result2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, carry-in add, subtracts, all issued back-to-back from DONE
    run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "t1");
    run8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "t2a");
    run8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, "t2b");
    run8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t3a");
    run8(1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, "t3b");
    repeat (3) @(negedge clk);
    chk("hold result", 32'(result), 32'h0000_00FF);
    chk("hold cout",   32'(cout),   32'd1);
    chk("hold busy",   32'(busy),   32'd0);

    // start held high through RUN with changing operands is ignored
    start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      a = 8'hAA; b = 8'h55;
    end while (!done && k < 40);
    chk("t4 latency", 32'(k),      32'd9);
    chk("t4 result",  32'(result), 32'h0000_0003);
    @(negedge clk);
    start = 1'b0;
    chk("t4 no gap busy", 32'(busy), 32'd1);
    chk("t4 no gap done", 32'(done), 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    chk("t4b latency", 32'(k),      32'd8);
    chk("t4b result",  32'(result), 32'h0000_00FF);
    chk("t4b ovf",     32'(ovf),    32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of slice 4
    start = 1'b1; mode = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 busy",   32'(busy),   32'd0);
    chk("t5 done",   32'(done),   32'd0);
    chk("t5 result", 32'(result), 32'd0);
    chk("t5 cout",   32'(cout),   32'd0);
    chk("t5 ovf",    32'(ovf),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5 no done after rst", 32'(ndone), 32'd0);
    run8(1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, "t5 fresh");
    @(negedge clk);

    // Wider instance, four bits per cycle
    run16(1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "t6a");
    run16(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t6b");
    run16(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "t6c");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor for WIDTH-bit operands. It processes BITS_PER_CYCLE bits per clock through a chained full-adder slice, with a registered carry between slices. It succeeds the single-bit combinational full adder/subtractor cells for datapaths that trade latency for area. It uses a start/busy/done handshake and produces carry/borrow and signed-overflow flags.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly, checked at elaboration.
(derived) N = WIDTH/BITS_PER_CYCLE, number of compute cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  add: carry-in; subtract: borrow-in; sampled with start
busy  output  1  high while computing
done  output  1  single-cycle pulse; results valid
result  output  WIDTH  sum or difference
cout  output  1  add: carry-out; subtract: borrow-out (1 = a < b+cin, unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset, async on rst_n=0: state=IDLE; busy, done, cout, ovf = 0; result = 0; internal operand, shift and carry registers = 0. Any in-progress operation is discarded and no done pulse follows.
- FSM states:
  - IDLE: busy=0, done=0. start=1 -> RUN.
  - RUN: busy=1, done=0. Stays in RUN until slice count reaches N-1, then -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 -> RUN; otherwise -> IDLE.
- Acceptance: start is sampled at a rising edge when busy=0, i.e. in IDLE or DONE. Back-to-back operation with start asserted in the DONE cycle is legal. start while busy=1 is ignored with no queuing.
- Latching on acceptance:
  - a_reg = a.
  - b_reg = mode ? ~b : b.
  - carry = mode ? ~cin : cin.
  - mode_reg = mode.
  - slice counter = 0.
  - a, b, mode and cin may change freely afterwards with no effect.
- Per RUN cycle k (0..N-1):
  - Slice bits [k*BPC +: BPC] of a_reg and b_reg are added with the carry through BPC chained full-adder stages.
  - The sum bits are written to result bits [k*BPC +: BPC].
  - The carry register updates to the carry out of the slice.
  - In the final slice, the carry into the MSB stage is captured in addition to the carry out of the MSB stage.
- Latency: the accepting edge is T. busy=1 for cycles T..T+N-1, and done=1 in the cycle after edge T+N. Start-to-done is N+1 edges. Throughput is one operation per N+1 cycles.
- Flags at DONE:
  - cout = mode_reg ? ~carry_out_msb : carry_out_msb.
  - ovf = carry_into_msb XOR carry_out_msb.
- Hold: result, cout and ovf stay stable from DONE until the next accepted start. They are not cleared on entry to IDLE.
- During RUN, result bits above the current slice hold previous contents; consumers read outputs only when done=1.
- Widths: all internal arithmetic is exactly WIDTH bits plus one carry; there are no truncation warnings.

Test Plan:
1. WIDTH=8, BPC=1, mode=0, a=8'h5A, b=8'h3C, cin=0 -> done exactly 9 edges after start; result=8'h96, cout=0, ovf=1; busy high for 8 cycles.
2. mode=0, a=8'hFF, b=8'h01, cin=1 -> result=8'h01, cout=1, ovf=0. Then mode=1, a=8'h10, b=8'h20, cin=0 -> result=8'hF0, cout=1 (borrow), ovf=0.
3. mode=1, a=8'h80, b=8'h01, cin=0 -> result=8'h7F, cout=0, ovf=1. Then mode=1, a=8'h05, b=8'h05, cin=1 -> result=8'hFF, cout=1, ovf=0.
4. Start a=8'h01, b=8'h02 (add). During RUN, hold start=1 and change a=8'hAA, b=8'h55 -> second request ignored; single done pulse with result=8'h03. Re-assert start in the DONE cycle -> new RUN begins next cycle with no IDLE gap.
5. Start an add, drive rst_n=0 asynchronously mid-cycle at RUN slice 4 -> busy, done, result, cout, ovf go to 0 immediately; no done after release. A fresh start after rst_n=1 completes correctly.
6. WIDTH=16, BPC=4, a=16'h1234, b=16'h0FCD, mode=0, cin=0 -> done 5 edges after start; result=16'h2201, cout=0, ovf=0. A further elaboration with BPC=3, WIDTH=16 must fail the parameter check.
